// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and state encoding for the instruction memory loader
package imem_pkg;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - instruction memory, synchronous write and combinational read
module imem_ram import imem_pkg::*; #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Contents deliberately have no reset so a program survives a core reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - loads a program into instruction memory, then serves core fetches
module imem_load_ctrl import imem_pkg::*; #(
  parameter int DEPTH = imem_pkg::DEPTH,
  parameter int AW    = imem_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          boot_skip,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic          core_run,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   load_cnt,
  output logic          err_misaligned,
  output logic          err_range
);

  state_t state, state_nxt;
  logic   beat;
  logic   range_bad;
  logic   misaligned;

  always_comb begin
    state_nxt   = state;
    core_run    = (state == ST_RUN);
    // Ready drops during reset so a beat coincident with reset is never written.
    ld_ready    = !core_run && !reset;
    beat        = ld_valid && ld_ready;
    range_bad   = |fetch_addr[31:AW+2];
    misaligned  = |fetch_addr[1:0];
    mem_we      = beat;
    mem_addr    = '0;
    mem_wdata   = '0;
    fetch_instr = NOP_INSTR;

    if (beat) begin
      mem_addr  = load_cnt[AW-1:0];
      mem_wdata = ld_data;
    end else if (core_run) begin
      mem_addr = fetch_addr[AW+1:2];
      if (!range_bad) begin
        fetch_instr = mem_rdata;
      end
    end

    case (state)
      ST_IDLE: begin
        if (ld_valid) begin
          state_nxt = ST_LOAD;
        end else if (boot_skip) begin
          state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (beat && (ld_last || load_cnt == (AW+1)'(DEPTH-1))) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      load_cnt       <= '0;
      err_misaligned <= 1'b0;
      err_range      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (beat && load_cnt != (AW+1)'(DEPTH)) begin
        load_cnt <= load_cnt + 1'b1;
      end
      if (core_run && range_bad) begin
        err_range <= 1'b1;
      end
      if (core_run && misaligned) begin
        err_misaligned <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl with imem_ram
module tb_imem_load_ctrl;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        boot_skip;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        core_run;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [10:0] load_cnt;
  logic        err_misaligned;
  logic        err_range;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_load_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .boot_skip      (boot_skip),
    .fetch_addr     (fetch_addr),
    .fetch_instr    (fetch_instr),
    .core_run       (core_run),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .load_cnt       (load_cnt),
    .err_misaligned (err_misaligned),
    .err_range      (err_range)
  );

  imem_ram u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    boot_skip  = 1'b0;
    fetch_addr = '0;
    @(negedge clk);
    step();
    reset = 1'b0;
    #1;
    chk("rst_core_run", core_run, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_load_cnt", load_cnt, 0);
    chk("rst_fetch_instr", fetch_instr, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_err_mis", err_misaligned, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    // three-word program, last word flagged
    ld_valid = 1'b1;
    ld_data  = 32'hFFC4A303;
    #1;
    chk("b0_mem_we", mem_we, 1);
    chk("b0_mem_addr", mem_addr, 0);
    chk("b0_mem_wdata", mem_wdata, 32'hFFC4A303);
    step();
    ld_valid = 1'b0;
    ld_data  = 32'h00500093;
    ld_valid = 1'b1;
    #1;
    chk("b1_mem_addr", mem_addr, 1);
    step();
    ld_valid = 1'b0;
    send(32'h00100113, 1'b1);
    chk("p3_load_cnt", load_cnt, 3);
    chk("p3_core_run", core_run, 1);
    chk("p3_ld_ready", ld_ready, 0);
    fetch_addr = 32'h8;
    #1;
    chk("p3_fetch8", fetch_instr, 32'h00100113);
    chk("p3_fetch8_we", mem_we, 0);
    chk("p3_fetch8_addr", mem_addr, 2);

    // out-of-range and misaligned fetches
    fetch_addr = 32'h0000_1000;
    #1;
    chk("range_instr", fetch_instr, 0);
    chk("range_flag_early", err_range, 0);
    step();
    chk("range_flag", err_range, 1);
    fetch_addr = 32'h6;
    #1;
    chk("mis_instr", fetch_instr, 32'h00500093);
    chk("mis_flag_early", err_misaligned, 0);
    step();
    chk("mis_flag", err_misaligned, 1);
    chk("mis_range_sticky", err_range, 1);
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    #1;
    chk("run_ld_we", mem_we, 0);
    chk("run_ld_ready", ld_ready, 0);
    step();
    ld_valid = 1'b0;
    chk("run_ld_cnt", load_cnt, 3);
    chk("run_stays", core_run, 1);

    // reset lands on the second beat of a load
    do_reset();
    #1;
    chk("r2_err_range", err_range, 0);
    chk("r2_err_mis", err_misaligned, 0);
    chk("r2_core_run", core_run, 0);
    send(32'h11111111, 1'b0);
    chk("r2_cnt1", load_cnt, 1);
    ld_valid = 1'b1;
    ld_data  = 32'h22222222;
    reset    = 1'b1;
    #1;
    chk("r2_rst_ready", ld_ready, 0);
    chk("r2_rst_we", mem_we, 0);
    step();
    reset    = 1'b0;
    ld_valid = 1'b0;
    #1;
    chk("r2_cnt0", load_cnt, 0);
    chk("r2_idle_run", core_run, 0);
    boot_skip = 1'b1;
    step();
    boot_skip = 1'b0;
    #1;
    chk("r2_skip_run", core_run, 1);
    fetch_addr = 32'h0;
    #1;
    chk("r2_word0", fetch_instr, 32'h11111111);
    fetch_addr = 32'h4;
    #1;
    chk("r2_word1_kept", fetch_instr, 32'h00500093);

    // boot_skip and ld_valid together: loading wins
    do_reset();
    boot_skip = 1'b1;
    ld_valid  = 1'b1;
    ld_data   = 32'hCAFEF00D;
    #1;
    chk("both_we", mem_we, 1);
    step();
    boot_skip = 1'b0;
    ld_valid  = 1'b0;
    #1;
    chk("both_not_run", core_run, 0);
    chk("both_cnt", load_cnt, 1);
    send(32'h0BADF00D, 1'b1);
    chk("both_run", core_run, 1);
    chk("both_cnt2", load_cnt, 2);
    fetch_addr = 32'h0;
    #1;
    chk("both_word0", fetch_instr, 32'hCAFEF00D);

    // full-depth load without ld_last
    do_reset();
    for (int i = 0; i < 1023; i++) begin
      send(32'h5A00_0000 | i, 1'b0);
    end
    chk("full_pre_run", core_run, 0);
    chk("full_pre_cnt", load_cnt, 1023);
    ld_valid = 1'b1;
    ld_data  = 32'h5A0003FF;
    #1;
    chk("full_last_addr", mem_addr, 1023);
    step();
    ld_valid = 1'b0;
    chk("full_run", core_run, 1);
    chk("full_cnt", load_cnt, 1024);
    ld_valid = 1'b1;
    ld_data  = 32'h77777777;
    #1;
    chk("full_extra_we", mem_we, 0);
    step();
    ld_valid = 1'b0;
    chk("full_cnt_sat", load_cnt, 1024);
    fetch_addr = 32'hFFC;
    #1;
    chk("full_word1023", fetch_instr, 32'h5A0003FF);
    fetch_addr = 32'h0;
    #1;
    chk("full_word0", fetch_instr, 32'h5A000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
